reset_sequencer: RTL

Orders the release of per-subsystem active-low resets within one clock domain. Inputs are already synchronized, for example by the per-clock reset synchronizer pipeline. Stages are released one at a time, in index order. Each stage must report done before the next stage is released, with a programmable gap between stages. The block flags faults and holds the design in reset until recovery.

---
 rtl/reset_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Sequenced release of per-stage active-low resets with done handshakes, inter-stage gap and fault hold.
// Optional WAIT timeout is compiled in when RESET_SEQ_TIMEOUT_EN is defined.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_soft_rstn,
  input  logic [NUM_STAGES-1:0]         i_stage_done,
  output logic [NUM_STAGES-1:0]         o_rstn_array,
  output logic                          o_all_ready,
  output logic                          o_error,
  output logic [$clog2(NUM_STAGES):0]   o_stage
);

  localparam int unsigned SW      = $clog2(NUM_STAGES) + 1;
  // A zero gap still costs one edge: release happens on the edge after done is sampled.
  localparam int unsigned GAP_EFF = (STAGE_GAP == 0) ? 1 : STAGE_GAP;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_EFF) ? HOLD_CYCLES : GAP_EFF;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  if ((NUM_STAGES < 1) || (NUM_STAGES > 16)) begin : g_bad_num_stages
    $error("reset_sequencer: NUM_STAGES must be 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("reset_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_WAIT  = 3'd1,
    S_GAP   = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [NUM_STAGES-1:0]   rstn_q, rstn_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]           wcnt_q, wcnt_d;
`endif

  logic                    cur_done;
  logic                    drop_found;
  logic [SW-1:0]           drop_idx;
  logic                    fault_go;
  logic [SW-1:0]           fault_idx;

  // Current stage's done, and lowest released stage whose done has fallen.
  always_comb begin
    cur_done   = 1'b0;
    drop_found = 1'b0;
    drop_idx   = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == SW'(i)) begin
        cur_done = i_stage_done[i];
      end
      if (!drop_found && !i_stage_done[i] &&
          ((state_q == S_RUN) ||
           ((state_q inside {S_WAIT, S_GAP}) && (SW'(i) < stage_q)))) begin
        drop_found = 1'b1;
        drop_idx   = SW'(i);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rstn_d    = rstn_q;
    ready_d   = ready_q;
    error_d   = error_q;
    fault_go  = 1'b0;
    fault_idx = stage_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    wcnt_d    = wcnt_q;
`endif

    if (!i_soft_rstn) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      stage_d = '0;
      rstn_d  = '0;
      ready_d = 1'b0;
      error_d = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      wcnt_d  = '0;
`endif
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            rstn_d  = NUM_STAGES'(1);
            stage_d = '0;
            cnt_d   = '0;
            state_d = S_WAIT;
`ifdef RESET_SEQ_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (drop_found) begin
            fault_go  = 1'b1;
            fault_idx = drop_idx;
          end else if (cur_done) begin
            if (stage_q == LAST_STAGE) begin
              ready_d = 1'b1;
              state_d = S_RUN;
            end else begin
              cnt_d   = '0;
              state_d = S_GAP;
            end
`ifdef RESET_SEQ_TIMEOUT_EN
          end else if (wcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            fault_go  = 1'b1;
            fault_idx = stage_q;
          end else begin
            wcnt_d = wcnt_q + TW'(1);
`endif
          end
        end
        S_GAP: begin
          if (drop_found) begin
            fault_go  = 1'b1;
            fault_idx = drop_idx;
          end else if (cnt_q == CW'(GAP_EFF - 1)) begin
            rstn_d  = (rstn_q << 1) | NUM_STAGES'(1);
            stage_d = stage_q + SW'(1);
            cnt_d   = '0;
            state_d = S_WAIT;
`ifdef RESET_SEQ_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (drop_found) begin
            fault_go  = 1'b1;
            fault_idx = drop_idx;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          stage_d = '0;
          rstn_d  = '0;
          ready_d = 1'b0;
        end
      endcase

      if (fault_go) begin
        state_d = S_FAULT;
        rstn_d  = '0;
        ready_d = 1'b0;
        error_d = 1'b1;
        stage_d = fault_idx;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      error_q <= error_d;
`ifdef RESET_SEQ_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign o_rstn_array = rstn_q;
  assign o_all_ready  = ready_q;
  assign o_error      = error_q;
  assign o_stage      = stage_q;

endmodule
